reg_wb_queue: RTL and testbench

Write-back queue that is the write-side companion of the register bank. It accepts write requests (register index plus data) from the execute and load paths over a valid/ready handshake and buffers them in a small FIFO. It drains one request per cycle onto the bank write port (`RegEn`, `WriteReg`, `WriteData`), which the bank samples on the rising clock edge. It also reports pending-write hazards for the two read addresses so the decode stage can stall or forward.

---
 rtl/reg_wb_queue_pkg.sv | 17 +
 rtl/reg_wb_queue_if.sv | 15 +
 rtl/reg_wb_queue_fifo.sv | 78 +++++++
 rtl/reg_wb_queue.sv | 122 ++++++++++++
 tb/tb_reg_wb_queue.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_wb_queue_pkg.sv
// Shared types and constants for the register write-back queue.
// The request struct is sized by DEFAULT_AW / DEFAULT_DW; the queue's AW/DW
// parameters default to the same values and are expected to match them.
package reg_wb_pkg;

    localparam int DEFAULT_AW = 5;
    localparam int DEFAULT_DW = 32;

    localparam logic [DEFAULT_AW-1:0] REG_ZERO = '0;

    // 'reg' is a keyword, so the register index field is called regIdx
    typedef struct packed {
        logic [DEFAULT_AW-1:0] regIdx;
        logic [DEFAULT_DW-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/reg_wb_queue_if.sv
// Write-request handshake into the write-back queue (valid/ready + payload).
interface reg_wb_queue_if
    import reg_wb_pkg::*;
#(
    parameter int AW = DEFAULT_AW,
    parameter int DW = DEFAULT_DW
);
    logic          InValid;
    logic          InReady;
    logic [AW-1:0] InReg;
    logic [DW-1:0] InData;

    modport master (output InValid, output InReg, output InData, input InReady);
    modport slave  (input InValid, input InReg, input InData, output InReady);
endinterface

// File: rtl/reg_wb_queue_fifo.sv
// wb_fifo: synchronous FIFO of write requests with wrap-bit pointers.
// Also presents every entry in age order (index 0 = head/oldest) so the
// parent can run hazard compares. The per-entry data view exists only when
// WB_BYPASS_EN is defined, since only forwarding needs it.
module wb_fifo
    import reg_wb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int IW    = $clog2(DEPTH),
    localparam int CW    = IW + 1
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                i_flush,
    input  logic                                i_push,
    input  wb_req_t                             i_pushReq,
    input  logic                                i_pop,
    output wb_req_t                             o_headReq,
    output logic [CW-1:0]                       o_count,
    output logic                                o_empty,
    output logic                                o_full,
    output logic [DEPTH-1:0]                    o_entryValid,
    output logic [DEPTH-1:0][DEFAULT_AW-1:0]    o_entryReg
`ifdef WB_BYPASS_EN
    ,
    output logic [DEPTH-1:0][DEFAULT_DW-1:0]    o_entryData
`endif
);

    wb_req_t       r_mem [DEPTH];
    logic [CW-1:0] r_wrPtr;
    logic [CW-1:0] r_rdPtr;
    logic          w_doPush;
    logic          w_doPop;

    assign o_count   = r_wrPtr - r_rdPtr;
    assign o_empty   = (r_wrPtr == r_rdPtr);
    assign o_full    = (r_wrPtr[IW-1:0] == r_rdPtr[IW-1:0]) && (r_wrPtr[IW] != r_rdPtr[IW]);
    assign w_doPush  = i_push && !o_full && !i_flush;
    assign w_doPop   = i_pop && !o_empty && !i_flush;
    assign o_headReq = r_mem[r_rdPtr[IW-1:0]];

    // Pointer update: flush empties the queue, otherwise advance on push/pop
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else if (i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + CW'(1);
            if (w_doPop)  r_rdPtr <= r_rdPtr + CW'(1);
        end
    end

    // Storage array; validity comes from the pointers so it needs no reset
    always_ff @(posedge i_clk) begin
        if (w_doPush) r_mem[r_wrPtr[IW-1:0]] <= i_pushReq;
    end

    // Age-ordered view of the occupied entries for the hazard compare
    always_comb begin
        o_entryValid = '0;
        o_entryReg   = '0;
`ifdef WB_BYPASS_EN
        o_entryData  = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            o_entryValid[k] = (CW'(k) < o_count);
            o_entryReg[k]   = r_mem[r_rdPtr[IW-1:0] + IW'(k)].regIdx;
`ifdef WB_BYPASS_EN
            o_entryData[k]  = r_mem[r_rdPtr[IW-1:0] + IW'(k)].data;
`endif
        end
    end

endmodule

// File: rtl/reg_wb_queue.sv
// reg_wb_queue: buffers register write requests and drains one per cycle
// onto the bank write port; flags pending writes to the decode read
// addresses. Define WB_BYPASS_EN to also forward the newest pending data.
module reg_wb_queue
    import reg_wb_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int AW    = DEFAULT_AW,
    parameter  int DW    = DEFAULT_DW,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic               Clk,
    input  logic               Rst_n,
    reg_wb_queue_if.slave      inIf,
    input  logic               Hold,
    input  logic               Flush,
    output logic               RegEn,
    output logic [AW-1:0]      WriteReg,
    output logic [DW-1:0]      WriteData,
    input  logic [AW-1:0]      ChkReg1,
    input  logic [AW-1:0]      ChkReg2,
    output logic               Hazard1,
    output logic               Hazard2,
    output logic [CW-1:0]      Count
`ifdef WB_BYPASS_EN
    ,
    output logic [DW-1:0]      FwdData1,
    output logic [DW-1:0]      FwdData2
`endif
);

    logic                   r_regEn;
    logic [AW-1:0]          r_writeReg;
    logic [DW-1:0]          r_writeData;

    wb_req_t                w_pushReq;
    wb_req_t                w_headReq;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_empty;
    logic                   w_full;
    logic [DEPTH-1:0]       w_entryValid;
    logic [DEPTH-1:0][AW-1:0] w_entryReg;
`ifdef WB_BYPASS_EN
    logic [DEPTH-1:0][DW-1:0] w_entryData;
`endif

    // r0 writes are acknowledged but never enqueued; flush drops a same-cycle push
    assign inIf.InReady     = !w_full;
    assign w_push           = inIf.InValid && !w_full && (inIf.InReg != AW'(REG_ZERO)) && !Flush;
    assign w_pop            = !w_empty && !Hold && !Flush;
    assign w_pushReq.regIdx = inIf.InReg;
    assign w_pushReq.data   = inIf.InData;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk        (Clk),
        .i_rst_n      (Rst_n),
        .i_flush      (Flush),
        .i_push       (w_push),
        .i_pushReq    (w_pushReq),
        .i_pop        (w_pop),
        .o_headReq    (w_headReq),
        .o_count      (Count),
        .o_empty      (w_empty),
        .o_full       (w_full),
        .o_entryValid (w_entryValid),
        .o_entryReg   (w_entryReg)
`ifdef WB_BYPASS_EN
        ,
        .o_entryData  (w_entryData)
`endif
    );

    // Output stage: registered bank write port, loaded from the FIFO head
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_regEn     <= 1'b0;
            r_writeReg  <= '0;
            r_writeData <= '0;
        end else if (w_pop) begin
            r_regEn     <= 1'b1;
            r_writeReg  <= w_headReq.regIdx;
            r_writeData <= w_headReq.data;
        end else begin
            r_regEn     <= 1'b0;
        end
    end

    assign RegEn     = r_regEn;
    assign WriteReg  = r_writeReg;
    assign WriteData = r_writeData;

    // True when any queued entry or the live output stage targets chk
    function automatic logic pendingHit(input logic [AW-1:0] chk);
        logic hit;
        hit = r_regEn && (r_writeReg == chk);
        for (int k = 0; k < DEPTH; k++) begin
            if (w_entryValid[k] && (w_entryReg[k] == chk)) hit = 1'b1;
        end
        return hit && (chk != AW'(REG_ZERO));
    endfunction

    assign Hazard1 = pendingHit(ChkReg1);
    assign Hazard2 = pendingHit(ChkReg2);

`ifdef WB_BYPASS_EN
    // Newest pending data for chk: youngest FIFO entry wins, output stage last
    function automatic logic [DW-1:0] newestData(input logic [AW-1:0] chk);
        logic [DW-1:0] d;
        d = '0;
        if (r_regEn && (r_writeReg == chk)) d = r_writeData;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_entryValid[k] && (w_entryReg[k] == chk)) d = w_entryData[k];
        end
        return d;
    endfunction

    assign FwdData1 = Hazard1 ? newestData(ChkReg1) : '0;
    assign FwdData2 = Hazard2 ? newestData(ChkReg2) : '0;
`endif

endmodule

// File: tb/tb_reg_wb_queue.sv
// Testbench for reg_wb_queue: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_reg_wb_queue;

    localparam int DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Hold;
    logic        Flush;
    logic        RegEn;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [4:0]  ChkReg1;
    logic [4:0]  ChkReg2;
    logic        Hazard1;
    logic        Hazard2;
    logic [2:0]  Count;
`ifdef WB_BYPASS_EN
    logic [31:0] FwdData1;
    logic [31:0] FwdData2;
`endif

    int checks = 0;
    int fails  = 0;
    bit cmpEn  = 1'b0;

    reg_wb_queue_if #(.AW(5), .DW(32)) inIf ();

    reg_wb_queue #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .inIf      (inIf),
        .Hold      (Hold),
        .Flush     (Flush),
        .RegEn     (RegEn),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .ChkReg1   (ChkReg1),
        .ChkReg2   (ChkReg2),
        .Hazard1   (Hazard1),
        .Hazard2   (Hazard2),
        .Count     (Count)
`ifdef WB_BYPASS_EN
        ,
        .FwdData1  (FwdData1),
        .FwdData2  (FwdData2)
`endif
    );

    always #5 Clk = ~Clk;

    // Reference model: a plain queue of pending writes plus the bank port
    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic        mEn;
    logic [4:0]  mReg;
    logic [31:0] mData;

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            mq.delete();
            mEn   = 1'b0;
            mReg  = '0;
            mData = '0;
        end else begin
            int   sizeBefore;
            ent_t e;
            sizeBefore = mq.size();
            if (Flush) begin
                mq.delete();
                mEn = 1'b0;
            end else begin
                if (sizeBefore > 0 && !Hold) begin
                    e     = mq.pop_front();
                    mEn   = 1'b1;
                    mReg  = e.r;
                    mData = e.d;
                end else begin
                    mEn = 1'b0;
                end
                if (inIf.InValid && sizeBefore < DEPTH && inIf.InReg != 5'd0) begin
                    e.r = inIf.InReg;
                    e.d = inIf.InData;
                    mq.push_back(e);
                end
            end
        end
    end

    function automatic bit modelHazard(input logic [4:0] c);
        if (c == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].r == c) return 1'b1;
        return mEn && (mReg == c);
    endfunction

    function automatic logic [31:0] modelFwd(input logic [4:0] c);
        if (c == 5'd0) return '0;
        for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].r == c) return mq[i].d;
        if (mEn && mReg == c) return mData;
        return '0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle, away from the rising edge, compare the DUT against the model
    always @(negedge Clk) begin
        if (cmpEn) begin
            checkOutput("model.RegEn",     32'(RegEn),        32'(mEn));
            checkOutput("model.WriteReg",  32'(WriteReg),     32'(mReg));
            checkOutput("model.WriteData", WriteData,         mData);
            checkOutput("model.Count",     32'(Count),        32'(mq.size()));
            checkOutput("model.InReady",   32'(inIf.InReady), 32'(mq.size() < DEPTH));
            checkOutput("model.Hazard1",   32'(Hazard1),      32'(modelHazard(ChkReg1)));
            checkOutput("model.Hazard2",   32'(Hazard2),      32'(modelHazard(ChkReg2)));
`ifdef WB_BYPASS_EN
            checkOutput("model.FwdData1",  FwdData1,          modelFwd(ChkReg1));
            checkOutput("model.FwdData2",  FwdData2,          modelFwd(ChkReg2));
`endif
        end
    end

    // Drive one cycle of inputs, then return just after the following falling edge
    task automatic applyStimulus(input bit v, input logic [4:0] r, input logic [31:0] d,
                                 input bit h, input bit f);
        inIf.InValid = v;
        inIf.InReg   = r;
        inIf.InData  = d;
        Hold         = h;
        Flush        = f;
        @(posedge Clk);
        @(negedge Clk);
        #1;
    endtask

    initial begin
        Rst_n        = 1'b0;
        Hold         = 1'b0;
        Flush        = 1'b0;
        ChkReg1      = '0;
        ChkReg2      = '0;
        inIf.InValid = 1'b0;
        inIf.InReg   = '0;
        inIf.InData  = '0;
        repeat (2) @(negedge Clk);
        #1;
        Rst_n = 1'b1;
        cmpEn = 1'b1;

        $display("[TB] reset values");
        checkOutput("rst.RegEn",     32'(RegEn), 0);
        checkOutput("rst.WriteReg",  32'(WriteReg), 0);
        checkOutput("rst.WriteData", WriteData, 0);
        checkOutput("rst.Count",     32'(Count), 0);
        checkOutput("rst.InReady",   32'(inIf.InReady), 1);
        checkOutput("rst.Hazard1",   32'(Hazard1), 0);
        checkOutput("rst.Hazard2",   32'(Hazard2), 0);

        $display("[TB] single write reg5");
        ChkReg1 = 5'd5;
        applyStimulus(1, 5'd5, 32'hDEADBEEF, 0, 0);
        checkOutput("single.RegEnN",   32'(RegEn), 0);
        checkOutput("single.CountN",   32'(Count), 1);
        checkOutput("single.HazardN",  32'(Hazard1), 1);
        applyStimulus(0, 5'd0, 32'h0, 0, 0);
        checkOutput("single.RegEnN1",  32'(RegEn), 1);
        checkOutput("single.WriteReg", 32'(WriteReg), 5);
        checkOutput("single.WriteData", WriteData, 32'hDEADBEEF);
        checkOutput("single.HazardN1", 32'(Hazard1), 1);
        applyStimulus(0, 5'd0, 32'h0, 0, 0);
        checkOutput("single.RegEnN2",  32'(RegEn), 0);
        checkOutput("single.HazardN2", 32'(Hazard1), 0);

        $display("[TB] fill under hold then drain");
        ChkReg1 = 5'd0;
        for (int i = 1; i <= 4; i++) applyStimulus(1, 5'(i), 32'h100 + 32'(i), 1, 0);
        checkOutput("hold.Count4",   32'(Count), 4);
        checkOutput("hold.Ready0",   32'(inIf.InReady), 0);
        applyStimulus(1, 5'd5, 32'h105, 1, 0);
        checkOutput("hold.Count4b",  32'(Count), 4);
        checkOutput("hold.RegEn0",   32'(RegEn), 0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 5'd0, 32'h0, 0, 0);
            checkOutput("drain.RegEn",     32'(RegEn), 1);
            checkOutput("drain.WriteReg",  32'(WriteReg), 32'(i));
            checkOutput("drain.WriteData", WriteData, 32'h100 + 32'(i));
            checkOutput("drain.Count",     32'(Count), 32'(4 - i));
        end
        applyStimulus(0, 5'd0, 32'h0, 0, 0);
        checkOutput("drain.RegEnEnd", 32'(RegEn), 0);
        checkOutput("drain.Ready1",   32'(inIf.InReady), 1);

        $display("[TB] write to r0");
        ChkReg2 = 5'd0;
        applyStimulus(1, 5'd0, 32'h55, 0, 0);
        checkOutput("r0.Count", 32'(Count), 0);
        applyStimulus(0, 5'd0, 32'h0, 0, 0);
        checkOutput("r0.RegEn",   32'(RegEn), 0);
        checkOutput("r0.Hazard2", 32'(Hazard2), 0);
        applyStimulus(0, 5'd0, 32'h0, 0, 0);
        checkOutput("r0.RegEnB",  32'(RegEn), 0);

        $display("[TB] same register twice");
        ChkReg1 = 5'd7;
        ChkReg2 = 5'd3;
        applyStimulus(1, 5'd7, 32'd1, 1, 0);
        applyStimulus(1, 5'd7, 32'd2, 1, 0);
        checkOutput("dup.Hazard1", 32'(Hazard1), 1);
        checkOutput("dup.Hazard2", 32'(Hazard2), 0);
        checkOutput("dup.Count",   32'(Count), 2);
`ifdef WB_BYPASS_EN
        checkOutput("dup.Fwd1", FwdData1, 32'd2);
        checkOutput("dup.Fwd2", FwdData2, 32'd0);
`endif
        applyStimulus(0, 5'd0, 32'h0, 0, 0);
        checkOutput("dup.first",  WriteData, 32'd1);
        applyStimulus(0, 5'd0, 32'h0, 0, 0);
        checkOutput("dup.second", WriteData, 32'd2);
        checkOutput("dup.RegEn",  32'(RegEn), 1);
        applyStimulus(0, 5'd0, 32'h0, 0, 0);
        checkOutput("dup.HazOff", 32'(Hazard1), 0);

        $display("[TB] flush with push");
        ChkReg1 = 5'd0;
        ChkReg2 = 5'd0;
        for (int i = 0; i < 3; i++) applyStimulus(1, 5'd9 + 5'(i), 32'h900 + 32'(i), 1, 0);
        checkOutput("flush.Count3", 32'(Count), 3);
        applyStimulus(1, 5'd12, 32'hC, 1, 1);
        checkOutput("flush.Count0", 32'(Count), 0);
        checkOutput("flush.RegEn",  32'(RegEn), 0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 5'd0, 32'h0, 0, 0);
            checkOutput("flush.noWrite", 32'(RegEn), 0);
        end

        $display("[TB] sustained stream with wrap");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 5'd1 + 5'(i), 32'h1000 + 32'(i), 0, 0);
            if (i >= 1) begin
                checkOutput("stream.RegEn",    32'(RegEn), 1);
                checkOutput("stream.WriteReg", 32'(WriteReg), 32'(i));
                checkOutput("stream.Count",    32'(Count), 1);
            end
        end
        applyStimulus(0, 5'd0, 32'h0, 0, 0);
        checkOutput("stream.lastReg",  32'(WriteReg), 10);
        checkOutput("stream.lastData", WriteData, 32'h1009);
        applyStimulus(0, 5'd0, 32'h0, 0, 0);
        checkOutput("stream.idle", 32'(RegEn), 0);

        $display("[TB] async reset mid-drain");
        for (int i = 0; i < 3; i++) applyStimulus(1, 5'd20 + 5'(i), 32'h2000 + 32'(i), 1, 0);
        applyStimulus(0, 5'd0, 32'h0, 0, 0);
        checkOutput("ares.RegEnPre", 32'(RegEn), 1);
        checkOutput("ares.CountPre", 32'(Count), 2);
        #2;
        Rst_n = 1'b0;
        #1;
        checkOutput("ares.RegEn",     32'(RegEn), 0);
        checkOutput("ares.WriteReg",  32'(WriteReg), 0);
        checkOutput("ares.WriteData", WriteData, 0);
        checkOutput("ares.Count",     32'(Count), 0);
        checkOutput("ares.InReady",   32'(inIf.InReady), 1);
        @(negedge Clk);
        #1;
        Rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 5'd0, 32'h0, 0, 0);
            checkOutput("ares.postRegEn", 32'(RegEn), 0);
            checkOutput("ares.postCount", 32'(Count), 0);
        end

        cmpEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
